// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
//   md_op_e    : operation select driven by the EX stage
//   md_state_e : control states of mips_muldiv
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Runs MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring) on operand
// magnitudes, one bit per RUN cycle, then applies the sign fixup in FIX.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_start, i_op      : launch request (IDLE only) and operation
//   i_a, i_b           : operands (rs, rt), sampled on the accepting edge
//   i_flush            : abort in-flight op / block IDLE actions
//   i_hi_we, i_lo_we   : MTHI/MTLO enables, i_wd write data
//   o_busy             : state != IDLE (registered)
//   o_done             : one-cycle pulse when a new result is on o_hi/o_lo
//   o_hi, o_lo         : HI/LO registers
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wd,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          r_state;
  logic               r_busy, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // mult: {partial, multiplier}; div: {rem, dividend/quot}
  logic [WIDTH-1:0]   r_m;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a_raw;  // dividend as presented, for divide-by-zero HI
  logic               r_is_div, r_neg_q, r_neg_r, r_bz;

  // Operand preparation (decoded from live inputs, latched on accept)
  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // One multiply step: conditional add into the upper half, keep the carry,
  // shift right by one.
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift the pair left, trial-subtract the divisor
  // from the widened remainder, keep the difference when it does not borrow.
  logic [WIDTH:0]     w_rsh, w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rsh      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rsh - {1'b0, r_m};
  assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign fixup applied on the FIX edge
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q, w_r;

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_q      = r_acc[WIDTH-1:0];
    w_r      = r_acc[2*WIDTH-1:WIDTH];
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_bz) begin
        // Divide by zero overrides any sign handling
        w_fix_lo = '1;
        w_fix_hi = r_a_raw;
      end else begin
        // most-negative / -1 wraps naturally: |q| = 2^(W-1), negated = itself
        w_fix_lo = r_neg_q ? -w_q : w_q;
        w_fix_hi = r_neg_r ? -w_r : w_r;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_hi_we) r_hi <= i_wd;
            if (i_lo_we) r_lo <= i_wd;
            if (i_start) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= i_op[1];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_bz     <= (i_b == '0);
              r_a_raw  <= i_a;
              r_acc    <= i_op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
              r_m      <= i_op[1] ? w_b_mag : w_a_mag;
            end
          end
          S_RUN: begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv (WIDTH=32): the driver pushes the
// expected HI/LO per launched op; a monitor pops on every done pulse.
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .i_flush(flush), .i_hi_we(hi_we), .i_lo_we(lo_we),
    .i_wd(wd), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
        check({nm, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
      end
    end
  end

  // Launch an op on the current negedge and wait for its done pulse.
  // Returns at the negedge where done is visible, so the next call issues
  // its start in the done cycle (back-to-back).
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit do_wd = 1'b0, input logic [W-1:0] xwd = '0);
    int n;
    bit got;
    exp_t e;
    start = 1'b1; op = o; a = xa; b = xb; hi_we = do_wd; wd = xwd;
    e.hi = eh; e.lo = el;
    exp_q.push_back(e);
    name_q.push_back(nm);
    n = 0; got = 1'b0;
    while (n < W + 10 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      if (do_wd && n == 1) check({nm, "_wd_first"}, {32'h0, hi}, {32'h0, xwd});
      if (done === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) check({nm, "_busy_run"}, {63'h0, busy}, 64'h1);
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done after %0d edges expected %0d", nm, n, W + 2);
    end else begin
      // Edges counted from the accepting edge inclusive
      check({nm, "_latency"}, 64'(n), 64'(W + 2));
      check({nm, "_busy_at_done"}, {63'h0, busy}, 64'h0);
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi",   {32'h0, hi}, 64'h0);
    check("reset_lo",   {32'h0, lo}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg3x7",   MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_ffxff",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m1xm1",    MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op("mult_7fx2",     MD_MULT,  32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE);
    run_op("mult_minxm1",   MD_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_7",    MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_7_0",      MD_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
    run_op("div_m7_0",      MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_0_0",       MD_DIV,   32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF);
    run_op("wd_then_multu", MD_MULTU, 32'd5,        32'd6,        32'h00000000, 32'd30, 1'b1, 32'h0000ABCD);

    // Flush on the 10th RUN cycle; a start and an MTHI issued while busy are ignored
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3; hi_we = 1'b1; wd = 32'h1234;
      end
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
    end
    check("flush_busy_before", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'h0, busy}, 64'h0);
    check("flush_hi",   {32'h0, hi}, 64'h0);
    check("flush_lo",   {32'h0, lo}, 64'd30);
    idle_cycles(W + 6);
    check("flush_hi_later", {32'h0, hi}, 64'h0);
    check("flush_busy_later", {63'h0, busy}, 64'h0);

    // Flush in IDLE drops both the start and the MTHI
    start = 1'b1; flush = 1'b1; hi_we = 1'b1; op = MD_MULT; a = 32'd2; b = 32'd2; wd = 32'h5555;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; hi_we = 1'b0;
    check("flush_start_busy", {63'h0, busy}, 64'h0);
    check("flush_start_hi",   {32'h0, hi}, 64'h0);

    // MTLO in IDLE
    lo_we = 1'b1; wd = 32'hCAFE0001;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", {32'h0, lo}, 64'hCAFE0001);

    // Reset mid-RUN
    start = 1'b1; op = MD_MULTU; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_hi",   {32'h0, hi}, 64'h0);
    check("midreset_lo",   {32'h0, lo}, 64'h0);
    check("midreset_busy", {63'h0, busy}, 64'h0);
    check("midreset_done", {63'h0, done}, 64'h0);
    idle_cycles(W + 6);

    run_op("after_reset_divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
